io_controller: RTL and testbench

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_ctrl_pkg.sv | 21 ++
 rtl/kb_fifo.sv | 51 +++++
 rtl/io_controller.sv | 151 +++++++++++++++
 tb/tb_io_controller.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the IO controller: register offsets, status bit
// positions and the sprite update state encoding.
package io_ctrl_pkg;

    localparam logic [31:0] OFF_KB_DATA    = 32'h0;
    localparam logic [31:0] OFF_KB_STATUS  = 32'h4;
    localparam logic [31:0] OFF_SPRITE_POS = 32'h8;
    localparam logic [31:0] OFF_FRAME_CNT  = 32'hC;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVERFLOW  = 1;
    localparam int ST_COUNT_LSB = 2;
    localparam int ST_COUNT_MSB = 5;
    localparam int ST_PENDING   = 6;

    typedef enum logic {
        SPR_IDLE  = 1'b0,
        SPR_ARMED = 1'b1
    } sprite_state_t;

endpackage

// File: rtl/kb_fifo.sv
// Keyboard scancode FIFO. A pop on empty is ignored; a push on full is
// accepted only when a pop frees a slot in the same cycle.
module kb_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_controller.sv
// Memory-mapped IO block: keyboard FIFO, frame-synchronous sprite position
// update and a frame counter driven by the VGA vertical sync.
//
// state     | meaning
// ----------+---------------------------------------------------------
// SPR_IDLE  | sprite outputs current, no pending position
// SPR_ARMED | pending position waits for next frame_tick to be applied
module io_controller
    import io_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    input  logic [7:0]  kb_code,
    input  logic        kb_valid,
    input  logic        vga_vs,
    output logic        mem_enb,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    output logic [9:0]  sprite_x,
    output logic [9:0]  sprite_y,
    output logic        frame_tick
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel_data, sel_status, sel_sprite, sel_frame;
    logic          wr_data, wr_status, wr_sprite;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          fifo_pop_eff;
    logic          overflow;
    logic          overflow_set;
    logic [9:0]    pend_x, pend_y;
    logic [15:0]   frame_cnt;
    logic          vs_meta, vs_sync, vs_prev;
    logic [31:0]   status_word;
    logic          load_sprite;
    logic          unused_wdata;
    sprite_state_t state, state_next;

    assign mem_enb    = (data_adr < IO_BASE);
    assign sel_data   = (data_adr == IO_BASE + OFF_KB_DATA);
    assign sel_status = (data_adr == IO_BASE + OFF_KB_STATUS);
    assign sel_sprite = (data_adr == IO_BASE + OFF_SPRITE_POS);
    assign sel_frame  = (data_adr == IO_BASE + OFF_FRAME_CNT);
    assign io_sel     = sel_data | sel_status | sel_sprite | sel_frame;

    assign wr_data    = mem_write & sel_data;
    assign wr_status  = mem_write & sel_status;
    assign wr_sprite  = mem_write & sel_sprite;

    assign unused_wdata = ^{write_data[31:26], write_data[15:10]};

    kb_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_kb_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (kb_valid),
        .din   (kb_code),
        .pop   (wr_data),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A push into a full FIFO is only a drop if no pop frees a slot this cycle.
    assign fifo_pop_eff = wr_data & ~fifo_empty;
    assign overflow_set = kb_valid & fifo_full & ~fifo_pop_eff;

    always_comb begin
        status_word                            = '0;
        status_word[ST_NOT_EMPTY]              = ~fifo_empty;
        status_word[ST_OVERFLOW]               = overflow;
        status_word[ST_COUNT_MSB:ST_COUNT_LSB] = 4'(fifo_count);
        status_word[ST_PENDING]                = (state == SPR_ARMED);
    end

    always_comb begin
        io_rdata = '0;
        if (sel_data)        io_rdata = {24'b0, fifo_head};
        else if (sel_status) io_rdata = status_word;
        else if (sel_frame)  io_rdata = {16'b0, frame_cnt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= vga_vs;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_tick = vs_prev & ~vs_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SPR_IDLE;
        else        state <= state_next;
    end

    // A store in the tick cycle keeps the FSM armed for the following frame.
    always_comb begin
        state_next  = state;
        load_sprite = 1'b0;
        case (state)
            SPR_IDLE: begin
                if (wr_sprite) state_next = SPR_ARMED;
            end
            SPR_ARMED: begin
                if (frame_tick) begin
                    load_sprite = 1'b1;
                    if (!wr_sprite) state_next = SPR_IDLE;
                end
            end
            default: state_next = SPR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            pend_x    <= '0;
            pend_y    <= '0;
            sprite_x  <= '0;
            sprite_y  <= '0;
            frame_cnt <= '0;
        end else begin
            if (overflow_set)                   overflow <= 1'b1;
            else if (wr_status && write_data[1]) overflow <= 1'b0;
            if (wr_sprite) begin
                pend_x <= write_data[9:0];
                pend_y <= write_data[25:16];
            end
            if (load_sprite) begin
                sprite_x <= pend_x;
                sprite_y <= pend_y;
            end
            if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: keyboard FIFO scoreboard, sprite
// frame timing, frame counter wrap and reset behaviour.
module tb_io_controller;

    localparam logic [31:0] BASE   = 32'h0000_0400;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_SPR  = BASE + 32'h8;
    localparam logic [31:0] A_FRM  = BASE + 32'hC;
    localparam logic [31:0] A_MEM  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_adr = A_MEM;
    logic [31:0] write_data = '0;
    logic        mem_write = 1'b0;
    logic [7:0]  kb_code = '0;
    logic        kb_valid = 1'b0;
    logic        vga_vs = 1'b1;
    logic        mem_enb, io_sel, frame_tick;
    logic [31:0] io_rdata;
    logic [9:0]  sprite_x, sprite_y;

    int total = 0;
    int bad = 0;

    logic [7:0]  kb_model[$];
    logic        exp_ovf = 1'b0;
    logic        exp_pend = 1'b0;
    logic [15:0] exp_frames = '0;

    io_controller #(.FIFO_DEPTH(8), .IO_BASE(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_adr   (data_adr),
        .write_data (write_data),
        .mem_write  (mem_write),
        .kb_code    (kb_code),
        .kb_valid   (kb_valid),
        .vga_vs     (vga_vs),
        .mem_enb    (mem_enb),
        .io_sel     (io_sel),
        .io_rdata   (io_rdata),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        return {25'b0, exp_pend, 4'(kb_model.size()), exp_ovf, (kb_model.size() != 0)};
    endfunction

    function automatic logic [31:0] exp_head();
        return (kb_model.size() != 0) ? {24'b0, kb_model[0]} : 32'h0;
    endfunction

    function automatic logic [31:0] spr_word(input logic [9:0] x, input logic [9:0] y);
        return {6'b0, y, 6'b0, x};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_reg(input logic [31:0] adr, output logic [31:0] v, output logic sel);
        data_adr = adr;
        #1;
        v = io_rdata;
        sel = io_sel;
        data_adr = A_MEM;
    endtask

    task automatic kb_push(input logic [7:0] code);
        kb_code = code;
        kb_valid = 1'b1;
        if (kb_model.size() < 8) kb_model.push_back(code);
        else exp_ovf = 1'b1;
        cyc(1);
        kb_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] d);
        data_adr = adr;
        write_data = d;
        mem_write = 1'b1;
        cyc(1);
        mem_write = 1'b0;
        data_adr = A_MEM;
    endtask

    task automatic kb_pop();
        store(A_DATA, 32'h0);
        if (kb_model.size() != 0) void'(kb_model.pop_front());
    endtask

    task automatic frame_fall();
        vga_vs = 1'b0;
        cyc(2);
    endtask

    task automatic frame_rise();
        vga_vs = 1'b1;
        cyc(3);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        s;
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        total++;
        if (mem_enb !== 1'b1 || io_sel !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem_decode got=%b%b want=10", mem_enb, io_sel);
        end
        read_reg(A_STAT, v, s);
        total++;
        if (v !== 32'h0 || s !== 1'b1) begin
            bad++;
            $display("FAIL reset_status got=%h sel=%b want=00000000 sel=1", v, s);
        end
        read_reg(A_FRM, v, s);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL reset_frame_cnt got=%h want=00000000", v);
        end
        total++;
        if (sprite_x !== 10'd0 || sprite_y !== 10'd0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got x=%h y=%h tick=%b want 0 0 0", sprite_x, sprite_y, frame_tick);
        end
        read_reg(BASE + 32'h10, v, s);
        total++;
        if (v !== 32'h0 || s !== 1'b0) begin
            bad++;
            $display("FAIL unmapped_io got=%h sel=%b want=00000000 sel=0", v, s);
        end
    endtask

    task automatic test_kb_basic();
        logic [31:0] v;
        logic        s;
        kb_push(8'h1C);
        kb_push(8'h32);
        for (int i = 0; i < 3; i++) begin
            read_reg(A_DATA, v, s);
            total++;
            if (v !== exp_head()) begin
                bad++;
                $display("FAIL kb_data_%0d got=%h want=%h", i, v, exp_head());
            end
            read_reg(A_STAT, v, s);
            total++;
            if (v !== exp_status()) begin
                bad++;
                $display("FAIL kb_status_%0d got=%h want=%h", i, v, exp_status());
            end
            kb_pop();
        end
        read_reg(A_STAT, v, s);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL pop_empty_status got=%h want=00000000", v);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic        s;
        for (int i = 0; i < 9; i++) kb_push(8'hA0 + 8'(i));
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status()) begin
            bad++;
            $display("FAIL overflow_status got=%h want=%h", v, exp_status());
        end
        store(A_STAT, 32'h2);
        exp_ovf = 1'b0;
        // push and pop together while full: both accepted, no overflow
        kb_code = 8'hB0;
        kb_valid = 1'b1;
        data_adr = A_DATA;
        mem_write = 1'b1;
        cyc(1);
        kb_valid = 1'b0;
        mem_write = 1'b0;
        data_adr = A_MEM;
        void'(kb_model.pop_front());
        kb_model.push_back(8'hB0);
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status()) begin
            bad++;
            $display("FAIL full_push_pop_status got=%h want=%h", v, exp_status());
        end
        // overflow set and clear in the same cycle: set wins
        kb_code = 8'hB1;
        kb_valid = 1'b1;
        data_adr = A_STAT;
        write_data = 32'h2;
        mem_write = 1'b1;
        cyc(1);
        kb_valid = 1'b0;
        mem_write = 1'b0;
        data_adr = A_MEM;
        exp_ovf = 1'b1;
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status()) begin
            bad++;
            $display("FAIL ovf_set_wins got=%h want=%h", v, exp_status());
        end
        store(A_STAT, 32'h2);
        exp_ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_reg(A_DATA, v, s);
            total++;
            if (v !== exp_head()) begin
                bad++;
                $display("FAIL drain_%0d got=%h want=%h", i, v, exp_head());
            end
            kb_pop();
        end
        // push and pop together while empty: pop ignored, push kept
        kb_code = 8'hB2;
        kb_valid = 1'b1;
        data_adr = A_DATA;
        mem_write = 1'b1;
        cyc(1);
        kb_valid = 1'b0;
        mem_write = 1'b0;
        data_adr = A_MEM;
        kb_model.push_back(8'hB2);
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status()) begin
            bad++;
            $display("FAIL empty_push_pop_status got=%h want=%h", v, exp_status());
        end
        read_reg(A_DATA, v, s);
        total++;
        if (v !== exp_head()) begin
            bad++;
            $display("FAIL empty_push_pop_data got=%h want=%h", v, exp_head());
        end
    endtask

    task automatic test_decode_ignore();
        logic [31:0] v;
        logic        s;
        store(BASE - 32'h4, 32'h0);
        store(BASE - 32'h8, spr_word(10'h3FF, 10'h3FF));
        store(BASE + 32'h10, 32'h0);
        store(A_FRM, 32'h1234);
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status()) begin
            bad++;
            $display("FAIL mem_store_ignored got=%h want=%h", v, exp_status());
        end
        read_reg(A_FRM, v, s);
        total++;
        if (v !== {16'b0, exp_frames}) begin
            bad++;
            $display("FAIL frame_cnt_readonly got=%h want=%h", v, {16'b0, exp_frames});
        end
        data_adr = BASE - 32'h1;
        #1;
        total++;
        if (mem_enb !== 1'b1) begin
            bad++;
            $display("FAIL mem_enb_below_base got=%b want=1", mem_enb);
        end
        data_adr = BASE;
        #1;
        total++;
        if (mem_enb !== 1'b0) begin
            bad++;
            $display("FAIL mem_enb_at_base got=%b want=0", mem_enb);
        end
        data_adr = A_MEM;
        kb_pop();
    endtask

    task automatic test_sprite();
        logic [31:0] v;
        logic        s;
        int          n;
        store(A_SPR, 32'h0064_00A0);
        exp_pend = 1'b1;
        cyc(3);
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status() || sprite_x !== 10'd0) begin
            bad++;
            $display("FAIL sprite_armed got status=%h x=%h want status=%h x=000", v, sprite_x, exp_status());
        end
        vga_vs = 1'b0;
        cyc(1);
        total++;
        if (frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL tick_at_k got=%b want=0", frame_tick);
        end
        cyc(1);
        total++;
        if (frame_tick !== 1'b1 || sprite_x !== 10'd0) begin
            bad++;
            $display("FAIL tick_at_k1 got tick=%b x=%h want tick=1 x=000", frame_tick, sprite_x);
        end
        cyc(1);
        exp_pend = 1'b0;
        exp_frames++;
        total++;
        if (frame_tick !== 1'b0 || {sprite_y, sprite_x} !== {10'h064, 10'h0A0}) begin
            bad++;
            $display("FAIL sprite_at_k2 got tick=%b y=%h x=%h want tick=0 y=064 x=0a0", frame_tick, sprite_y, sprite_x);
        end
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status()) begin
            bad++;
            $display("FAIL sprite_pending_clear got=%h want=%h", v, exp_status());
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (frame_tick) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL vs_held_low_ticks got=%0d want=0", n);
        end
        frame_rise();
    endtask

    task automatic test_coincident();
        logic [31:0] v;
        logic        s;
        store(A_SPR, spr_word(10'd1, 10'd2));
        exp_pend = 1'b1;
        frame_fall();
        total++;
        if (frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL coinc_tick_armed got=%b want=1", frame_tick);
        end
        store(A_SPR, spr_word(10'd3, 10'd4));
        exp_frames++;
        read_reg(A_STAT, v, s);
        total++;
        if ({sprite_y, sprite_x} !== {10'd2, 10'd1} || v !== exp_status()) begin
            bad++;
            $display("FAIL coinc_armed_old got y=%0d x=%0d st=%h want y=2 x=1 st=%h", sprite_y, sprite_x, v, exp_status());
        end
        frame_rise();
        frame_fall();
        cyc(1);
        exp_frames++;
        exp_pend = 1'b0;
        total++;
        if ({sprite_y, sprite_x} !== {10'd4, 10'd3}) begin
            bad++;
            $display("FAIL coinc_armed_new got y=%0d x=%0d want y=4 x=3", sprite_y, sprite_x);
        end
        frame_rise();
        frame_fall();
        store(A_SPR, spr_word(10'd5, 10'd6));
        exp_frames++;
        exp_pend = 1'b1;
        read_reg(A_STAT, v, s);
        total++;
        if ({sprite_y, sprite_x} !== {10'd4, 10'd3} || v !== exp_status()) begin
            bad++;
            $display("FAIL coinc_idle got y=%0d x=%0d st=%h want y=4 x=3 st=%h", sprite_y, sprite_x, v, exp_status());
        end
        frame_rise();
        frame_fall();
        cyc(1);
        exp_frames++;
        exp_pend = 1'b0;
        frame_rise();
        read_reg(A_FRM, v, s);
        total++;
        if ({sprite_y, sprite_x} !== {10'd6, 10'd5} || v !== {16'b0, exp_frames}) begin
            bad++;
            $display("FAIL coinc_idle_apply got y=%0d x=%0d cnt=%h want y=6 x=5 cnt=%h", sprite_y, sprite_x, v, exp_frames);
        end
    endtask

    task automatic test_frame_wrap();
        logic [31:0] v;
        logic        s;
        int          n;
        n = 32'hFFFF - int'(exp_frames);
        for (int i = 0; i < n; i++) begin
            vga_vs = 1'b0;
            cyc(1);
            vga_vs = 1'b1;
            cyc(1);
        end
        cyc(3);
        exp_frames = 16'hFFFF;
        read_reg(A_FRM, v, s);
        total++;
        if (v !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL frame_cnt_max got=%h want=0000ffff", v);
        end
        frame_fall();
        cyc(1);
        exp_frames = exp_frames + 16'd1;
        read_reg(A_FRM, v, s);
        total++;
        if (v !== {16'b0, exp_frames}) begin
            bad++;
            $display("FAIL frame_cnt_wrap got=%h want=%h", v, {16'b0, exp_frames});
        end
        frame_rise();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        s;
        int          n;
        kb_push(8'h11);
        kb_push(8'h22);
        kb_push(8'h33);
        store(A_SPR, spr_word(10'd7, 10'd8));
        reset = 1'b0;
        #2;
        kb_model.delete();
        exp_ovf = 1'b0;
        exp_pend = 1'b0;
        exp_frames = '0;
        read_reg(A_STAT, v, s);
        total++;
        if (v !== exp_status()) begin
            bad++;
            $display("FAIL mid_reset_status got=%h want=%h", v, exp_status());
        end
        read_reg(A_FRM, v, s);
        total++;
        if (v !== 32'h0 || sprite_x !== 10'd0 || sprite_y !== 10'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got cnt=%h x=%h y=%h want 0 0 0", v, sprite_x, sprite_y);
        end
        cyc(1);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            if (frame_tick) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL tick_after_release got=%0d want=0", n);
        end
        frame_fall();
        cyc(1);
        exp_frames++;
        frame_rise();
        read_reg(A_FRM, v, s);
        total++;
        if ({sprite_y, sprite_x} !== 20'd0 || v !== {16'b0, exp_frames}) begin
            bad++;
            $display("FAIL pending_discarded got y=%h x=%h cnt=%h want 0 0 %h", sprite_y, sprite_x, v, exp_frames);
        end
    endtask

    initial begin
        test_reset();
        test_kb_basic();
        test_overflow();
        test_decode_ignore();
        test_sprite();
        test_coincident();
        test_frame_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
